// File: rtl/victim_refill_if.sv
// Miss-handling bundle between the cache front end, the bus, the tag array and the LRU controller.
// The slave modport is the victim/refill FSM. The master modport is everything around it.
`timescale 1ns/1ps
interface victim_refill_if #(
    parameter int NUM_WAYS    = 4,
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 24
);
    localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH;

    logic                          miss_valid;
    logic                          miss_ready;
    logic [ADDR_WIDTH-1:0]         miss_addr;
    logic                          miss_is_write;
    logic [NUM_WAYS-1:0]           way_valid;
    logic [NUM_WAYS-1:0]           way_dirty;
    logic [NUM_WAYS*TAG_WIDTH-1:0] way_tag;
    logic [1:0]                    lru_way;
    logic                          wb_req_valid;
    logic                          wb_req_ready;
    logic [ADDR_WIDTH-1:0]         wb_req_addr;
    logic                          fill_req_valid;
    logic                          fill_req_ready;
    logic [ADDR_WIDTH-1:0]         fill_req_addr;
    logic                          fill_req_excl;
    logic                          fill_resp_valid;
    logic                          install_valid;
    logic [NUM_WAYS-1:0]           install_way;
    logic [1:0]                    install_state;
    logic                          access_valid;
    logic [NUM_WAYS-1:0]           access_way;
    logic                          busy;

    modport master (
        output miss_valid, miss_addr, miss_is_write, way_valid, way_dirty, way_tag, lru_way,
               wb_req_ready, fill_req_ready, fill_resp_valid,
        input  miss_ready, wb_req_valid, wb_req_addr, fill_req_valid, fill_req_addr,
               fill_req_excl, install_valid, install_way, install_state, access_valid,
               access_way, busy
    );

    modport slave (
        input  miss_valid, miss_addr, miss_is_write, way_valid, way_dirty, way_tag, lru_way,
               wb_req_ready, fill_req_ready, fill_resp_valid,
        output miss_ready, wb_req_valid, wb_req_addr, fill_req_valid, fill_req_addr,
               fill_req_excl, install_valid, install_way, install_state, access_valid,
               access_way, busy
    );
endinterface

// File: rtl/victim_refill_fsm.sv
// Cache miss handler. It picks a victim way (invalid ways first, then LRU) and writes the victim back if it is dirty.
// It then fetches the line, installs it in S or M state, and reports the MRU access to the LRU controller.
`timescale 1ns/1ps
module victim_refill_fsm #(
    parameter int NUM_WAYS    = 4,
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 24
) (
    input logic            clk,
    input logic            rst_n,
    victim_refill_if.slave bus
);
    localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH;

    typedef enum logic [2:0] {IDLE, SELECT, WB_REQ, FILL_REQ, FILL_WAIT, INSTALL} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  excl_q;
    logic [NUM_WAYS-1:0]   victim_q;
    logic [TAG_WIDTH-1:0]  victim_tag_q;
    logic                  wb_valid_q;
    logic                  fill_valid_q;
    logic                  install_valid_q;
    logic [NUM_WAYS-1:0]   install_way_q;
    logic [1:0]            install_state_q;

    logic [1:0]            sel_idx;
    logic [NUM_WAYS-1:0]   sel_onehot;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic                  sel_dirty;

    // Descending scan so the lowest-numbered invalid way overrides the LRU choice.
    always_comb begin
        sel_idx = bus.lru_way;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!bus.way_valid[i]) begin
                sel_idx = 2'(i);
            end
        end
        sel_onehot = NUM_WAYS'(1) << sel_idx;
        sel_tag    = bus.way_tag[int'(sel_idx) * TAG_WIDTH +: TAG_WIDTH];
        sel_dirty  = bus.way_valid[sel_idx] & bus.way_dirty[sel_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            addr_q          <= '0;
            excl_q          <= 1'b0;
            victim_q        <= '0;
            victim_tag_q    <= '0;
            wb_valid_q      <= 1'b0;
            fill_valid_q    <= 1'b0;
            install_valid_q <= 1'b0;
            install_way_q   <= '0;
            install_state_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_valid) begin
                        addr_q <= bus.miss_addr;
                        excl_q <= bus.miss_is_write;
                        state  <= SELECT;
                    end
                end
                SELECT: begin
                    victim_q     <= sel_onehot;
                    victim_tag_q <= sel_tag;
                    if (sel_dirty) begin
                        wb_valid_q <= 1'b1;
                        state      <= WB_REQ;
                    end else begin
                        fill_valid_q <= 1'b1;
                        state        <= FILL_REQ;
                    end
                end
                WB_REQ: begin
                    if (bus.wb_req_ready) begin
                        wb_valid_q   <= 1'b0;
                        fill_valid_q <= 1'b1;
                        state        <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (bus.fill_req_ready) begin
                        fill_valid_q <= 1'b0;
                        state        <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (bus.fill_resp_valid) begin
                        install_valid_q <= 1'b1;
                        install_way_q   <= victim_q;
                        install_state_q <= excl_q ? 2'b10 : 2'b01;
                        state           <= INSTALL;
                    end
                end
                INSTALL: begin
                    install_valid_q <= 1'b0;
                    install_way_q   <= '0;
                    install_state_q <= 2'b00;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miss_ready     = (state == IDLE);
    assign bus.busy           = (state != IDLE);
    assign bus.wb_req_valid   = wb_valid_q;
    assign bus.wb_req_addr    = {victim_tag_q, addr_q[INDEX_WIDTH-1:0]};
    assign bus.fill_req_valid = fill_valid_q;
    assign bus.fill_req_addr  = addr_q;
    assign bus.fill_req_excl  = excl_q;
    assign bus.install_valid  = install_valid_q;
    assign bus.install_way    = install_way_q;
    assign bus.install_state  = install_state_q;
    assign bus.access_valid   = install_valid_q;
    assign bus.access_way     = install_way_q;
endmodule

// File: tb/tb_victim_refill_fsm.sv
// Scoreboard bench for victim_refill_fsm.
// Directed misses push hand-computed writeback, fill and install expectations, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_victim_refill_fsm;
    localparam int NUM_WAYS    = 4;
    localparam int INDEX_WIDTH = 6;
    localparam int TAG_WIDTH   = 24;
    localparam int ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    int   ready_leaks = 0;
    bit   in_miss = 1'b0;

    logic [ADDR_WIDTH-1:0]    wb_q[$];
    logic [ADDR_WIDTH:0]      fill_q[$];
    logic [NUM_WAYS+1:0]      inst_q[$];
    logic [ADDR_WIDTH-1:0]    wb_e;
    logic [ADDR_WIDTH:0]      fill_e;
    logic [NUM_WAYS+1:0]      inst_e;
    logic [NUM_WAYS*TAG_WIDTH-1:0] plain_tags;

    victim_refill_if #(.NUM_WAYS(NUM_WAYS), .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)) vif();

    victim_refill_fsm #(.NUM_WAYS(NUM_WAYS), .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected responses for a miss are pushed here, before any stimulus is driven.
    task automatic applyStimulus(
        input logic [ADDR_WIDTH-1:0]         addr,
        input logic                          wr,
        input logic [NUM_WAYS-1:0]           valid,
        input logic [NUM_WAYS-1:0]           dirty,
        input logic [NUM_WAYS*TAG_WIDTH-1:0] tags,
        input logic [1:0]                    lru,
        input bit                            exp_wb,
        input logic [ADDR_WIDTH-1:0]         exp_wb_addr,
        input bit                            exp_inst,
        input logic [NUM_WAYS-1:0]           exp_way,
        input logic [1:0]                    exp_state,
        input bit                            hold
    );
        int n;
        if (exp_wb) wb_q.push_back(exp_wb_addr);
        fill_q.push_back({wr, addr});
        if (exp_inst) inst_q.push_back({exp_way, exp_state});
        vif.miss_addr     = addr;
        vif.miss_is_write = wr;
        vif.way_valid     = valid;
        vif.way_dirty     = dirty;
        vif.way_tag       = tags;
        vif.lru_way       = lru;
        vif.miss_valid    = 1'b1;
        n = 0;
        while (!vif.miss_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("accept_ready", vif.miss_ready, 1);
        tick();
        if (!hold) vif.miss_valid = 1'b0;
        in_miss = 1'b1;
    endtask

    task automatic serveMiss(input bit exp_wb, input int wb_wait, input int fill_wait,
                             input bit stray, input bit resp_at_hs, input int resp_k);
        int n;
        int held;
        if (exp_wb) begin
            n = 0;
            while (!vif.wb_req_valid && n < 20) begin
                tick();
                n++;
            end
            checkOutput("wb_req_seen", vif.wb_req_valid, 1);
            held = 0;
            for (int i = 0; i < wb_wait; i++) begin
                if (vif.wb_req_valid) held++;
                tick();
            end
            if (vif.wb_req_valid) held++;
            vif.wb_req_ready = 1'b1;
            tick();
            vif.wb_req_ready = 1'b0;
            checkOutput("wb_held_cycles", held, wb_wait + 1);
        end
        n = 0;
        while (!vif.fill_req_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("fill_req_seen", vif.fill_req_valid, 1);
        held = 0;
        for (int i = 0; i < fill_wait; i++) begin
            if (vif.fill_req_valid) held++;
            if (stray && i == 2) vif.fill_resp_valid = 1'b1;
            tick();
            vif.fill_resp_valid = 1'b0;
        end
        if (vif.fill_req_valid) held++;
        checkOutput("fill_held_cycles", held, fill_wait + 1);
        vif.fill_req_ready = 1'b1;
        if (resp_at_hs) vif.fill_resp_valid = 1'b1;
        tick();
        vif.fill_req_ready  = 1'b0;
        vif.fill_resp_valid = 1'b0;
        for (int i = 1; i < resp_k; i++) begin
            checkOutput("no_early_install", vif.install_valid, 0);
            tick();
        end
        checkOutput("fill_wait_busy", vif.busy, 1);
        vif.fill_resp_valid = 1'b1;
        tick();
        vif.fill_resp_valid = 1'b0;
        checkOutput("install_strobe", vif.install_valid, 1);
        tick();
        in_miss = 1'b0;
        checkOutput("ready_low_during_miss", ready_leaks, 0);
        checkOutput("idle_after_install", vif.miss_ready, 1);
    endtask

    // Monitor: compares every bus handshake and install strobe against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_miss && vif.miss_ready) ready_leaks++;
            if (vif.wb_req_valid && vif.wb_req_ready) begin
                if (wb_q.size() == 0) checkOutput("wb_unexpected", vif.wb_req_valid, 0);
                else begin
                    wb_e = wb_q.pop_front();
                    checkOutput("wb_addr", vif.wb_req_addr, wb_e);
                end
            end
            if (vif.fill_req_valid && vif.fill_req_ready) begin
                if (fill_q.size() == 0) checkOutput("fill_unexpected", vif.fill_req_valid, 0);
                else begin
                    fill_e = fill_q.pop_front();
                    checkOutput("fill_addr", vif.fill_req_addr, fill_e[ADDR_WIDTH-1:0]);
                    checkOutput("fill_excl", vif.fill_req_excl, fill_e[ADDR_WIDTH]);
                end
            end
            if (vif.install_valid) begin
                if (inst_q.size() == 0) checkOutput("install_unexpected", vif.install_valid, 0);
                else begin
                    inst_e = inst_q.pop_front();
                    checkOutput("install_way", vif.install_way, inst_e[NUM_WAYS+1:2]);
                    checkOutput("install_state", vif.install_state, inst_e[1:0]);
                    checkOutput("access_valid", vif.access_valid, 1);
                    checkOutput("access_way", vif.access_way, inst_e[NUM_WAYS+1:2]);
                end
            end
        end
    end

    initial begin
        int n;
        plain_tags          = {24'h000333, 24'h000222, 24'h000111, 24'h000000};
        vif.miss_valid      = 1'b0;
        vif.miss_addr       = '0;
        vif.miss_is_write   = 1'b0;
        vif.way_valid       = '0;
        vif.way_dirty       = '0;
        vif.way_tag         = '0;
        vif.lru_way         = 2'd0;
        vif.wb_req_ready    = 1'b0;
        vif.fill_req_ready  = 1'b0;
        vif.fill_resp_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_miss_ready", vif.miss_ready, 1);
        checkOutput("rst_busy", vif.busy, 0);
        checkOutput("rst_wb_valid", vif.wb_req_valid, 0);
        checkOutput("rst_fill_valid", vif.fill_req_valid, 0);
        checkOutput("rst_install_valid", vif.install_valid, 0);
        checkOutput("rst_wb_addr", vif.wb_req_addr, 0);
        checkOutput("rst_fill_addr", vif.fill_req_addr, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] invalid-way preference");
        applyStimulus({24'h123456, 6'h0A}, 1'b0, 4'b1011, 4'b0001, plain_tags, 2'd0,
                      1'b0, '0, 1'b1, 4'b0100, 2'b01, 1'b0);
        serveMiss(1'b0, 0, 0, 1'b0, 1'b0, 1);

        $display("[TB] LRU victim, store miss, response coincident with handshake ignored");
        applyStimulus({24'h00C0DE, 6'h21}, 1'b1, 4'b1111, 4'b0000, plain_tags, 2'd3,
                      1'b0, '0, 1'b1, 4'b1000, 2'b10, 1'b0);
        serveMiss(1'b0, 0, 1, 1'b0, 1'b1, 3);

        $display("[TB] dirty victim writeback");
        applyStimulus({24'h111111, 6'h15}, 1'b0, 4'b1111, 4'b0010,
                      {24'h777777, 24'h555555, 24'hABCDEF, 24'h999999}, 2'd1,
                      1'b1, {24'hABCDEF, 6'h15}, 1'b1, 4'b0010, 2'b01, 1'b0);
        serveMiss(1'b1, 3, 0, 1'b0, 1'b0, 2);

        $display("[TB] fill backpressure with stray response");
        applyStimulus({24'h2468AC, 6'h3F}, 1'b1, 4'b0111, 4'b0000, plain_tags, 2'd2,
                      1'b0, '0, 1'b1, 4'b1000, 2'b10, 1'b0);
        serveMiss(1'b0, 0, 5, 1'b1, 1'b0, 2);

        $display("[TB] back-to-back misses");
        applyStimulus({24'h0BEEF0, 6'h01}, 1'b0, 4'b1111, 4'b0000, plain_tags, 2'd2,
                      1'b0, '0, 1'b1, 4'b0100, 2'b01, 1'b1);
        serveMiss(1'b0, 0, 0, 1'b0, 1'b0, 1);
        checkOutput("b2b_ready_after_install", vif.miss_ready, 1);
        fill_q.push_back({1'b0, 24'h0BEEF0, 6'h01});
        inst_q.push_back({4'b0100, 2'b01});
        tick();
        vif.miss_valid = 1'b0;
        in_miss = 1'b1;
        checkOutput("b2b_second_accepted", vif.busy, 1);
        serveMiss(1'b0, 0, 0, 1'b0, 1'b0, 1);

        $display("[TB] reset during FILL_WAIT");
        applyStimulus({24'hFEDCBA, 6'h07}, 1'b0, 4'b1111, 4'b0000, plain_tags, 2'd0,
                      1'b0, '0, 1'b0, 4'b0000, 2'b00, 1'b0);
        n = 0;
        while (!vif.fill_req_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("rst_test_fill_seen", vif.fill_req_valid, 1);
        vif.fill_req_ready = 1'b1;
        tick();
        vif.fill_req_ready = 1'b0;
        tick();
        in_miss = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_miss_ready", vif.miss_ready, 1);
        checkOutput("midrst_busy", vif.busy, 0);
        checkOutput("midrst_install_valid", vif.install_valid, 0);
        checkOutput("midrst_access_valid", vif.access_valid, 0);
        checkOutput("midrst_fill_addr", vif.fill_req_addr, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        vif.fill_resp_valid = 1'b1;
        tick();
        vif.fill_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("postrst_no_install", vif.install_valid, 0);
            checkOutput("postrst_idle", vif.miss_ready, 1);
            tick();
        end

        checkOutput("wb_queue_drained", wb_q.size(), 0);
        checkOutput("fill_queue_drained", fill_q.size(), 0);
        checkOutput("install_queue_drained", inst_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
